mac_job_scheduler: RTL and testbench

// - Queues matrix-multiply job descriptors and sequences the shared MyMAC engine one job at a time.
// - Per job, drives the MAC base addresses, operand-source selects and dimension overrides, then pulses mac_valid.
// - Optionally chains a job's result base to the previous job's last result write + 1.
// - Sits between the top-level attention FSM (producer of Q/K/V/S/Z jobs) and the MAC.

---
 rtl/ece564_pkg.sv | 29 ++
 rtl/job_desc_fifo.sv | 68 ++++++
 rtl/mac_job_scheduler.sv | 178 +++++++++++++++++
 tb/tb_mac_job_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ece564_pkg.sv
// Shared types for the MAC job scheduler slice.
//   ADDR_W / DATA_W : SRAM address and data widths (dims packed {rows[15:0],cols[15:0]})
//   job_desc_t      : one queued matrix-multiply job descriptor
//   sched_state_e   : scheduler FSM states
package ece564_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] res_base;
    logic              src_a;
    logic              src_b;
    logic              ovr;
    logic [DATA_W-1:0] in_dims;
    logic [DATA_W-1:0] wt_dims;
    logic              chain;
  } job_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } sched_state_e;

endpackage

// File: rtl/job_desc_fifo.sv
// Descriptor FIFO for the MAC job scheduler.
//   clk, reset_n : clock, async active-low reset (empties the FIFO)
//   push, push_data : write request and descriptor (ignored while full)
//   pop          : read request (ignored while empty)
//   head         : descriptor at the read pointer, valid while !empty
//   full, empty  : occupancy flags
module job_desc_fifo
  import ece564_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  job_desc_t push_data,
  input  logic      pop,
  output job_desc_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  // DEPTH+1 occupancy states keep full and empty distinct.
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  job_desc_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mac_job_scheduler.sv
// Queues matrix-multiply job descriptors and runs the shared MAC one job at a time.
//   job_*          : descriptor producer interface (valid/ready)
//   mac_valid      : one-cycle start pulse; mac_ready: MAC idle/done
//   mac_*_base, mac_src_*, mac_ovr, mac_*_dims : active job config, held between jobs
//   mac_wr_en/addr : MAC result writes, tracked for result-base chaining
//   busy, job_done, jobs_done : status
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no job running; pop head when FIFO non-empty and MAC ready
// LAUNCH    | mac_valid high for this single cycle
// WAIT_BUSY | wait for MAC to drop ready; ready high 2 cycles => 1x1 job done
// WAIT_DONE | MAC running; ready rising completes the job
module mac_job_scheduler
  import ece564_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_a_base,
  input  logic [ADDR_W-1:0] job_b_base,
  input  logic [ADDR_W-1:0] job_res_base,
  input  logic              job_src_a,
  input  logic              job_src_b,
  input  logic              job_ovr,
  input  logic [DATA_W-1:0] job_in_dims,
  input  logic [DATA_W-1:0] job_wt_dims,
  input  logic              job_chain,
  output logic              mac_valid,
  input  logic              mac_ready,
  output logic [ADDR_W-1:0] mac_a_base,
  output logic [ADDR_W-1:0] mac_b_base,
  output logic [ADDR_W-1:0] mac_res_base,
  output logic              mac_src_a,
  output logic              mac_src_b,
  output logic              mac_ovr,
  output logic [DATA_W-1:0] mac_in_dims,
  output logic [DATA_W-1:0] mac_wt_dims,
  input  logic              mac_wr_en,
  input  logic [ADDR_W-1:0] mac_wr_addr,
  output logic              busy,
  output logic              job_done,
  output logic [CNT_W-1:0]  jobs_done
);

  job_desc_t    job_in, head;
  logic         fifo_full, fifo_empty, pop, done;
  sched_state_e state_q, state_d;
  logic         wb_tmr_q, wb_tmr_d;
  logic         job_done_q, job_done_d;
  logic [CNT_W-1:0]  jobs_done_q, jobs_done_d;
  logic [ADDR_W-1:0] last_wr_q, last_wr_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, res_base_q, res_base_d;
  logic              src_a_q, src_a_d, src_b_q, src_b_d, ovr_q, ovr_d;
  logic [DATA_W-1:0] in_dims_q, in_dims_d, wt_dims_q, wt_dims_d;

  assign job_in = '{a_base: job_a_base, b_base: job_b_base, res_base: job_res_base,
                    src_a: job_src_a, src_b: job_src_b, ovr: job_ovr,
                    in_dims: job_in_dims, wt_dims: job_wt_dims, chain: job_chain};

  job_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (job_valid),
    .push_data (job_in),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    wb_tmr_d   = wb_tmr_q;
    pop        = 1'b0;
    done       = 1'b0;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    res_base_d = res_base_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    ovr_d      = ovr_q;
    in_dims_d  = in_dims_q;
    wt_dims_d  = wt_dims_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && mac_ready) begin
          pop        = 1'b1;
          state_d    = LAUNCH;
          a_base_d   = head.a_base;
          b_base_d   = head.b_base;
          // Chain resolves here, after the previous job has fully completed.
          res_base_d = head.chain ? last_wr_q + ADDR_W'(1) : head.res_base;
          src_a_d    = head.src_a;
          src_b_d    = head.src_b;
          ovr_d      = head.ovr;
          in_dims_d  = head.ovr ? head.in_dims : '0;
          wt_dims_d  = head.ovr ? head.wt_dims : '0;
        end
      end
      LAUNCH: begin
        state_d  = WAIT_BUSY;
        wb_tmr_d = 1'b1;
      end
      WAIT_BUSY: begin
        if (!mac_ready) begin
          state_d = WAIT_DONE;
        end else if (wb_tmr_q == 1'b0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          wb_tmr_d = wb_tmr_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (mac_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    job_done_d  = done;
    jobs_done_d = done ? jobs_done_q + CNT_W'(1) : jobs_done_q;
    last_wr_d   = mac_wr_en ? mac_wr_addr : last_wr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wb_tmr_q    <= 1'b0;
      job_done_q  <= 1'b0;
      jobs_done_q <= '0;
      last_wr_q   <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      res_base_q  <= '0;
      src_a_q     <= 1'b0;
      src_b_q     <= 1'b0;
      ovr_q       <= 1'b0;
      in_dims_q   <= '0;
      wt_dims_q   <= '0;
    end else begin
      state_q     <= state_d;
      wb_tmr_q    <= wb_tmr_d;
      job_done_q  <= job_done_d;
      jobs_done_q <= jobs_done_d;
      last_wr_q   <= last_wr_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      res_base_q  <= res_base_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      ovr_q       <= ovr_d;
      in_dims_q   <= in_dims_d;
      wt_dims_q   <= wt_dims_d;
    end
  end

  assign job_ready    = !fifo_full;
  assign mac_valid    = (state_q == LAUNCH);
  assign busy         = (state_q != IDLE) || !fifo_empty;
  assign job_done     = job_done_q;
  assign jobs_done    = jobs_done_q;
  assign mac_a_base   = a_base_q;
  assign mac_b_base   = b_base_q;
  assign mac_res_base = res_base_q;
  assign mac_src_a    = src_a_q;
  assign mac_src_b    = src_b_q;
  assign mac_ovr      = ovr_q;
  assign mac_in_dims  = in_dims_q;
  assign mac_wt_dims  = wt_dims_q;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Randomised bench for mac_job_scheduler with a job-level reference model.
module tb_mac_job_scheduler;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, job_valid, job_ready;
  logic [15:0] job_a_base, job_b_base, job_res_base;
  logic        job_src_a, job_src_b, job_ovr, job_chain;
  logic [31:0] job_in_dims, job_wt_dims;
  logic        mac_valid, mac_ready;
  logic [15:0] mac_a_base, mac_b_base, mac_res_base;
  logic        mac_src_a, mac_src_b, mac_ovr;
  logic [31:0] mac_in_dims, mac_wt_dims;
  logic        mac_wr_en;
  logic [15:0] mac_wr_addr;
  logic        busy, job_done;
  logic [7:0]  jobs_done;

  mac_job_scheduler #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a_base(job_a_base), .job_b_base(job_b_base), .job_res_base(job_res_base),
    .job_src_a(job_src_a), .job_src_b(job_src_b), .job_ovr(job_ovr),
    .job_in_dims(job_in_dims), .job_wt_dims(job_wt_dims), .job_chain(job_chain),
    .mac_valid(mac_valid), .mac_ready(mac_ready),
    .mac_a_base(mac_a_base), .mac_b_base(mac_b_base), .mac_res_base(mac_res_base),
    .mac_src_a(mac_src_a), .mac_src_b(mac_src_b), .mac_ovr(mac_ovr),
    .mac_in_dims(mac_in_dims), .mac_wt_dims(mac_wt_dims),
    .mac_wr_en(mac_wr_en), .mac_wr_addr(mac_wr_addr),
    .busy(busy), .job_done(job_done), .jobs_done(jobs_done)
  );

  typedef struct {
    logic [15:0] a, b, res;
    logic        sa, sb, ovr, chain;
    logic [31:0] ind, wtd;
  } tjob_t;

  // Reference model: a queue of waiting jobs plus the job currently on the MAC.
  tjob_t       m_q[$];
  logic        m_active, m_low, m_done;
  int          m_age;      // cycles since the job was taken from the queue
  logic [15:0] m_last, m_a, m_b, m_res;
  logic        m_sa, m_sb, m_ovr;
  logic [31:0] m_in, m_wt;
  logic [7:0]  m_jobs;

  int n_chk = 0, n_pass = 0, cyc_n = 0;
  int pre = 0, dur = 0, low_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_low = 0; m_done = 0; m_age = 0;
    m_last = 0; m_a = 0; m_b = 0; m_res = 0;
    m_sa = 0; m_sb = 0; m_ovr = 0; m_in = 0; m_wt = 0; m_jobs = 0;
  endtask

  // Applies the job rules to the inputs that were stable across the edge just taken.
  task automatic model_update();
    tjob_t d, cur;
    bit done_now, pop_now, push_now;
    if (!reset_n) begin
      model_reset();
      return;
    end
    done_now = 0;
    if (m_active && m_age >= 2) begin
      if (!mac_ready) m_low = 1;
      else if (m_low || m_age == 3) done_now = 1;  // dropped then rose, or never dropped in 2 cycles
    end
    pop_now  = !m_active && (m_q.size() > 0) && mac_ready;
    push_now = job_valid && (m_q.size() < DEPTH);
    if (pop_now) begin
      d = m_q.pop_front();
      m_a = d.a; m_b = d.b; m_sa = d.sa; m_sb = d.sb; m_ovr = d.ovr;
      m_res = d.chain ? m_last + 16'd1 : d.res;
      m_in  = d.ovr ? d.ind : 32'd0;
      m_wt  = d.ovr ? d.wtd : 32'd0;
      m_active = 1; m_age = 1; m_low = 0;
    end else if (m_active) begin
      m_age++;
    end
    if (done_now) begin
      m_active = 0;
      m_jobs++;
    end
    m_done = done_now;
    if (push_now) begin
      cur = '{a: job_a_base, b: job_b_base, res: job_res_base, sa: job_src_a, sb: job_src_b,
              ovr: job_ovr, chain: job_chain, ind: job_in_dims, wtd: job_wt_dims};
      m_q.push_back(cur);
    end
    if (mac_wr_en) m_last = mac_wr_addr;
  endtask

  task automatic compare();
    chk("job_ready", job_ready, m_q.size() < DEPTH);
    chk("busy", busy, m_active || m_q.size() != 0);
    chk("mac_valid", mac_valid, m_active && m_age == 1);
    chk("job_done", job_done, m_done);
    chk("jobs_done", jobs_done, m_jobs);
    chk("mac_a_base", mac_a_base, m_a);
    chk("mac_b_base", mac_b_base, m_b);
    chk("mac_res_base", mac_res_base, m_res);
    chk("mac_src_a", mac_src_a, m_sa);
    chk("mac_src_b", mac_src_b, m_sb);
    chk("mac_ovr", mac_ovr, m_ovr);
    chk("mac_in_dims", mac_in_dims, m_in);
    chk("mac_wt_dims", mac_wt_dims, m_wt);
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_update();
    cyc_n++;
    @(negedge clk);
    compare();
  endtask

  task automatic set_job(input tjob_t j);
    job_a_base = j.a; job_b_base = j.b; job_res_base = j.res;
    job_src_a = j.sa; job_src_b = j.sb; job_ovr = j.ovr; job_chain = j.chain;
    job_in_dims = j.ind; job_wt_dims = j.wtd;
  endtask

  function automatic tjob_t mk(input logic [15:0] a, input logic [15:0] res, input logic ovr,
                               input logic chain);
    tjob_t j;
    j = '{a: a, b: 16'h0001, res: res, sa: 1'b1, sb: 1'b0, ovr: ovr, chain: chain,
          ind: 32'h0004_0008, wtd: 32'h0008_0002};
    return j;
  endfunction

  function automatic tjob_t rand_job();
    tjob_t j;
    j.a = 16'($urandom); j.b = 16'($urandom); j.res = 16'($urandom);
    j.sa = 1'($urandom); j.sb = 1'($urandom); j.ovr = 1'($urandom);
    j.chain = ($urandom_range(0, 3) == 0);
    j.ind = $urandom; j.wtd = $urandom;
    return j;
  endfunction

  task automatic push_job(input tjob_t j);
    int t = 0;
    set_job(j);
    job_valid = 1;
    while (!job_ready && t < 50) begin cyc(); t++; end
    chk("push_wait", job_ready, 1);
    cyc();
    job_valid = 0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!mac_valid && t < 60) begin cyc(); t++; end
    chk("valid_timeout", mac_valid, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!job_done && t < 60) begin cyc(); t++; end
    chk("done_timeout", job_done, 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_mac_valid"}, mac_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_job_ready"}, job_ready, 1);
    chk({tag, "_job_done"}, job_done, 0);
    chk({tag, "_jobs_done"}, jobs_done, 0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    reset_checks("reset");
    chk("reset_res_base", mac_res_base, 0);
    cyc(); cyc();
    reset_n = 1;
  endtask

  initial begin
    int nvalid, cv;
    tjob_t j;
    reset_n = 0; job_valid = 0; mac_ready = 1; mac_wr_en = 0; mac_wr_addr = 0;
    set_job(mk(0, 0, 0, 0));
    model_reset();
    @(negedge clk);
    do_reset();

    // A: single job, MAC busy from cycle 2 to 19, done pulse expected in cycle 21.
    push_job(mk(16'h0001, 16'h0000, 1, 0));
    nvalid = 0;
    for (int c = 0; c <= 21; c++) begin
      if (mac_valid) nvalid++;
      if (c == 1) begin
        chk("A_valid_c1", mac_valid, 1);
        chk("A_a_base", mac_a_base, 16'h0001);
        chk("A_res_base", mac_res_base, 16'h0000);
      end
      if (c >= 1) chk("A_in_dims_hold", mac_in_dims, 32'h0004_0008);
      if (c == 20) chk("A_no_done_c20", job_done, 0);
      if (c == 21) begin
        chk("A_done_c21", job_done, 1);
        chk("A_jobs_done", jobs_done, 1);
      end
      mac_ready = !(c >= 2 && c < 20);
      if (c < 21) cyc();
    end
    chk("A_one_valid", nvalid, 1);
    cyc();

    // B: five pushes with the MAC held busy; fifth waits for the first pop.
    mac_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("B_ready_before_push", job_ready, 1);
      set_job(mk(16'h0100 + 16'(i), 16'h0, 0, 0));
      job_valid = 1;
      cyc();
    end
    chk("B_ready_low_full", job_ready, 0);
    set_job(mk(16'h0104, 16'h0, 0, 0));
    cyc(); cyc();
    chk("B_fifth_refused", job_ready, 0);
    mac_ready = 1;
    cyc();
    chk("B_ready_after_pop", job_ready, 1);
    chk("B_first_valid", mac_valid, 1);
    chk("B_order_0", mac_a_base, 16'h0100);
    cyc();
    job_valid = 0;
    for (int k = 1; k < 5; k++) begin
      wait_valid();
      cv = cyc_n;
      chk("B_fifo_order", mac_a_base, 16'h0100 + 16'(k));
      chk("B_ovr0_dims", mac_in_dims, 0);
      wait_done();
      chk("B_1x1_latency", cyc_n - cv, 3);
    end
    chk("B_jobs_done", jobs_done, 6);

    // C: chained result bases, including wrap past 0xFFFF.
    cyc();
    mac_wr_en = 1; mac_wr_addr = 16'h0017;
    cyc();
    mac_wr_en = 0;
    push_job(mk(16'h0200, 16'hABCD, 1, 1));
    wait_valid();
    chk("C_chain_0018", mac_res_base, 16'h0018);
    wait_done();
    mac_wr_en = 1; mac_wr_addr = 16'hFFFF;
    cyc();
    mac_wr_en = 0;
    push_job(mk(16'h0201, 16'hABCD, 1, 1));
    wait_valid();
    chk("C_chain_wrap", mac_res_base, 16'h0000);
    wait_done();
    push_job(mk(16'h0202, 16'h1234, 1, 0));
    wait_valid();
    chk("C_unchained", mac_res_base, 16'h1234);
    wait_done();

    // D: random producer and reactive MAC, model-checked every cycle.
    pre = 0; low_left = 0;
    for (int n = 0; n < 3000; n++) begin
      j = rand_job();
      set_job(j);
      job_valid = 1'($urandom);
      if (mac_valid) begin
        if ($urandom_range(0, 3) == 0) pre = 0;
        else begin
          pre = $urandom_range(1, 2);
          dur = $urandom_range(1, 8);
        end
      end else if (pre > 0) begin
        pre--;
        if (pre == 0) low_left = dur;
      end
      if (low_left > 0) begin
        mac_ready = 0;
        low_left--;
      end else begin
        mac_ready = m_active ? 1'b1 : ($urandom_range(0, 7) != 0);
      end
      mac_wr_en = !mac_ready && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: mac_wr_addr = 16'hFFFF;
        1: mac_wr_addr = 16'h0017;
        default: mac_wr_addr = 16'($urandom);
      endcase
      cyc();
    end
    job_valid = 0; mac_wr_en = 0; mac_ready = 1;

    // E: reset while in WAIT_DONE with three queued jobs.
    do_reset();
    push_job(mk(16'h0300, 16'h0, 0, 0));
    wait_valid();
    cyc();
    mac_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      set_job(mk(16'h0300 + 16'(i), 16'h0, 0, 0));
      job_valid = 1;
      cyc();
    end
    job_valid = 0;
    cyc();
    chk("E_busy_before", busy, 1);
    chk("E_jobs_done_before", jobs_done, 0);
    reset_n = 0;
    #1;
    reset_checks("E_async");
    mac_ready = 1;
    cyc();
    reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("E_no_done", job_done, 0);
      chk("E_no_launch", mac_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
